dcm_clkgen_prog: RTL and testbench

- Serial programming master for a Spartan-6 DCM_CLKGEN reconfiguration port (PROGCLK/PROGEN/PROGDATA/PROGDONE).
- Accepts a runtime M/D frequency request from host-side control logic and shifts the LoadD, LoadM and GO commands into the DCM.
- Waits for PROGDONE, then reports completion, so the hashing clock can be retuned without a bitstream reload.
- Sits beside the clock-management tiles; CLK is the clock also driven onto PROGCLK.

---
 rtl/dcm_clkgen_prog_pkg.sv | 32 +++
 rtl/dcm_clkgen_prog_if.sv | 20 ++
 rtl/dcm_prog_shifter.sv | 47 ++++
 rtl/dcm_clkgen_prog.sv | 146 ++++++++++++++
 tb/tb_dcm_clkgen_prog.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dcm_clkgen_prog_pkg.sv
// Shared definitions for the DCM_CLKGEN serial programming master:
// FSM states, command opcodes, command lengths and the command word builder.
package dcm_clkgen_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_D,
    ST_GAP1,
    ST_LOAD_M,
    ST_GAP2,
    ST_GO,
    ST_WAIT_DONE
  } state_e;

  // Opcodes written in transmission order: the MSB goes out first.
  localparam logic [1:0] OP_LOAD_D = 2'b10;
  localparam logic [1:0] OP_LOAD_M = 2'b11;

  localparam int         CMD_LEN = 10;
  localparam logic [3:0] CMD_LEN_C = 4'(CMD_LEN);
  localparam logic [3:0] GO_LEN  = 4'd1;
  localparam int         GAP_MIN = 2;

  // Builds a 10-bit command word whose bit 0 is shifted out first:
  // opcode (two bits), then (value-1)[7:0] LSB-first.
  function automatic logic [CMD_LEN-1:0] make_cmd(logic [1:0] op, logic [8:0] val);
    logic [7:0] vm1;
    vm1 = 8'(val - 9'd1);
    return {vm1, op[0], op[1]};
  endfunction

endpackage

// File: rtl/dcm_clkgen_prog_if.sv
// Host-side request/status bundle of the DCM_CLKGEN programming master.
interface dcm_clkgen_prog_if;
  logic       req_valid;
  logic       req_ready;
  logic [8:0] req_m;
  logic [8:0] req_d;
  logic       done;
  logic       err;
  logic       busy;

  modport master (
    output req_valid, req_m, req_d,
    input  req_ready, done, err, busy
  );

  modport slave (
    input  req_valid, req_m, req_d,
    output req_ready, done, err, busy
  );
endinterface

// File: rtl/dcm_prog_shifter.sv
// Loads one command word plus its bit length and shifts it LSB-first onto
// PROGDATA while holding PROGEN high; flags the final bit with last.
module dcm_prog_shifter
  import dcm_clkgen_prog_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [CMD_LEN-1:0] word,
  input  logic [3:0]         len,
  output logic               progen,
  output logic               progdata,
  output logic               last
);
  logic [CMD_LEN-1:0] sreg;
  logic [3:0]         cnt;

  assign last = progen && (cnt == 4'd0);

  // Pin drivers: registered so PROGEN/PROGDATA change only on PROGCLK edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      progen   <= 1'b0;
      progdata <= 1'b0;
    end else if (load) begin
      progen   <= 1'b1;
      progdata <= word[0];
    end else if (last) begin
      progen   <= 1'b0;
      progdata <= 1'b0;
    end else if (progen) begin
      progdata <= sreg[0];
    end
  end

  // Shift register and down-counting bit counter; progen qualifies them, so no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      sreg <= word >> 1;
      cnt  <= len - 4'd1;
    end else if (progen && cnt != 4'd0) begin
      sreg <= sreg >> 1;
      cnt  <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/dcm_clkgen_prog.sv
// dcm_clkgen_prog: serial programming master for a Spartan-6 DCM_CLKGEN.
// Sequences LoadD, LoadM and GO through the PROG port, then waits for the
// PROGDONE 1->0->1 handshake before pulsing done.
// Optional PROGDONE timeout: define DCM_CLKGEN_PROG_TIMEOUT_EN.
module dcm_clkgen_prog
  import dcm_clkgen_prog_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int M_MAX          = 256,
  parameter int D_MAX          = 256,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             CLK,
  input  logic             RESET,
  dcm_clkgen_prog_if.slave host,
  output logic             PROGEN,
  output logic             PROGDATA,
  input  logic             PROGDONE
);
  // Gaps shorter than the DCM minimum are clamped up to it.
  localparam int         GAP_EFF = (GAP_CYCLES < GAP_MIN) ? GAP_MIN : GAP_CYCLES;
  localparam int         GAP_W   = $clog2(GAP_EFF + 1);
  localparam logic [8:0] M_MAX_C = 9'(M_MAX);
  localparam logic [8:0] D_MAX_C = 9'(D_MAX);

  state_e             state, state_nxt;
  logic [8:0]         m_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic               seen_low;
  logic               done_q, err_q;
  logic               accept, legal;
  logic               wait_live, fin, tmo, to_hit;
  logic               sh_load, sh_last;
  logic [CMD_LEN-1:0] sh_word;
  logic [3:0]         sh_len;

  function automatic logic req_legal(logic [8:0] m, logic [8:0] d);
    return (m >= 9'd2) && (m <= M_MAX_C) && (d >= 9'd1) && (d <= D_MAX_C);
  endfunction

  assign accept    = (state == ST_IDLE) && host.req_valid;
  assign legal     = req_legal(host.req_m, host.req_d);
  assign wait_live = (state == ST_WAIT_DONE) && !done_q && !err_q;
  assign fin       = wait_live && seen_low && PROGDONE;
  assign tmo       = wait_live && !fin && to_hit;

`ifdef DCM_CLKGEN_PROG_TIMEOUT_EN
  logic [15:0] to_cnt;

  // PROGDONE watchdog: cleared on GO, counts every WAIT_DONE cycle.
  always_ff @(posedge CLK) begin
    if (state == ST_GO) to_cnt <= 16'd0;
    else if (state == ST_WAIT_DONE) to_cnt <= to_cnt + 16'd1;
  end

  assign to_hit = (state == ST_WAIT_DONE) && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  dcm_prog_shifter u_shifter (
    .clk      (CLK),
    .rst      (RESET),
    .load     (sh_load),
    .word     (sh_word),
    .len      (sh_len),
    .progen   (PROGEN),
    .progdata (PROGDATA),
    .last     (sh_last)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (accept && legal)         state_nxt = ST_LOAD_D;
      ST_LOAD_D:    if (sh_last)                 state_nxt = ST_GAP1;
      ST_GAP1:      if (gap_cnt == '0)           state_nxt = ST_LOAD_M;
      ST_LOAD_M:    if (sh_last)                 state_nxt = ST_GAP2;
      ST_GAP2:      if (gap_cnt == '0)           state_nxt = ST_GO;
      ST_GO:                                     state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done_q || err_q)         state_nxt = ST_IDLE;
      default:                                   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: status flags and shifter loads (D word comes straight from the request).
  always_comb begin
    sh_load        = 1'b0;
    sh_word        = '0;
    sh_len         = CMD_LEN_C;
    host.busy      = (state != ST_IDLE);
    host.req_ready = (state == ST_IDLE);
    case (state)
      ST_IDLE: if (accept && legal) begin
        sh_load = 1'b1;
        sh_word = make_cmd(OP_LOAD_D, host.req_d);
      end
      ST_GAP1: if (gap_cnt == '0) begin
        sh_load = 1'b1;
        sh_word = make_cmd(OP_LOAD_M, m_q);
      end
      ST_GAP2: if (gap_cnt == '0) begin
        sh_load = 1'b1;
        sh_len  = GO_LEN;
      end
      default: ;
    endcase
  end

  assign host.done = done_q;
  assign host.err  = err_q;

  // Multiplier is held for the LoadM command issued after the first gap.
  always_ff @(posedge CLK) begin
    if (accept) m_q <= host.req_m;
  end

  // Gap timer: armed on the last bit of a LOAD command, drains through the GAP state.
  always_ff @(posedge CLK) begin
    if (RESET)                                                 gap_cnt <= '0;
    else if ((state == ST_LOAD_D || state == ST_LOAD_M) && sh_last) gap_cnt <= GAP_W'(GAP_EFF - 1);
    else if (gap_cnt != '0)                                    gap_cnt <= gap_cnt - 1'b1;
  end

  // PROGDONE handshake: only a low seen after GO arms completion; pulses are one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      seen_low <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state == ST_GO)                                seen_low <= 1'b0;
      else if (state == ST_WAIT_DONE && !PROGDONE)       seen_low <= 1'b1;
      done_q <= fin;
      err_q  <= (accept && !legal) || tmo;
    end
  end

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
// Bench for dcm_clkgen_prog: stimulus pushes expected PROG bits / done / err
// events into a queue, a negedge monitor pops and compares them.
module tb_dcm_clkgen_prog;
  localparam int GAP = 2;
`ifdef DCM_CLKGEN_PROG_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif
  localparam int K_BIT  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int   kind;
    logic val;
    int   gap;
  } ev_t;

  // Transmission order is bit 0 first.
  localparam logic [9:0] VD_8   = 10'b0000011101;
  localparam logic [9:0] VM_35  = 10'b0010001011;
  localparam logic [9:0] VD_256 = 10'b1111111101;
  localparam logic [9:0] VM_256 = 10'b1111111111;
  localparam logic [9:0] VD_1   = 10'b0000000001;
  localparam logic [9:0] VM_2   = 10'b0000000111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic progen, progdata;
  logic progdone = 1'b1;
  int   checks = 0;
  int   failures = 0;
  ev_t  expq[$];

  dcm_clkgen_prog_if bus();

  dcm_clkgen_prog #(
    .GAP_CYCLES(GAP), .M_MAX(256), .D_MAX(256), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(clk), .RESET(rst), .host(bus),
    .PROGEN(progen), .PROGDATA(progdata), .PROGDONE(progdone)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_expect(string name, int kind, output ev_t e, output logic ok);
    checks++;
    ok = 1'b0;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL %s: got event with empty queue, expected no event", name);
    end else begin
      e = expq.pop_front();
      ok = 1'b1;
      checks--;
      check({name, "_kind"}, e.kind, kind);
    end
  endtask

  // Monitor: compares every observed PROG bit, done and err against the queue.
  initial begin : monitor
    int   low_run;
    ev_t  e;
    logic ok;
    low_run = 0;
    forever begin
      @(negedge clk);
      if (progen) begin
        pop_expect("prog_bit", K_BIT, e, ok);
        if (ok) begin
          check("progdata", progdata, e.val);
          if (e.gap >= 0) check("gap_len", low_run, e.gap);
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      if (bus.done) begin
        pop_expect("done_evt", K_DONE, e, ok);
        check("err_with_done", bus.err, 1'b0);
      end
      if (bus.err) pop_expect("err_evt", K_ERR, e, ok);
    end
  end

  task automatic push_cmd(logic [9:0] v, int first_gap, int nbits);
    for (int i = 0; i < nbits; i++) expq.push_back('{K_BIT, v[i], (i == 0) ? first_gap : 0});
  endtask

  task automatic push_full(logic [9:0] vd, logic [9:0] vm);
    push_cmd(vd, -1, 10);
    push_cmd(vm, GAP, 10);
    expq.push_back('{K_BIT, 1'b0, GAP});
  endtask

  task automatic issue(logic [8:0] m, logic [8:0] d);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_m = m; bus.req_d = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Legal request with a DCM that drops PROGDONE 3 cycles after GO and raises it 20 later.
  task automatic run_ok(logic [8:0] m, logic [8:0] d, logic [9:0] vd, logic [9:0] vm);
    push_full(vd, vm);
    expq.push_back('{K_DONE, 1'b0, 0});
    issue(m, d);
    check("busy_after_accept", bus.busy, 1'b1);
    check("ready_after_accept", bus.req_ready, 1'b0);
    check("progen_rise", progen, 1'b1);
    repeat (24) @(posedge clk); #1;
    check("go_progen", progen, 1'b1);
    check("go_progdata", progdata, 1'b0);
    repeat (3) @(posedge clk); #1;
    progdone = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("no_early_done", bus.done, 1'b0);
    check("busy_waiting", bus.busy, 1'b1);
    progdone = 1'b1;
    @(posedge clk); #1;
    check("done_pulse", bus.done, 1'b1);
    @(posedge clk); #1;
    check("done_single", bus.done, 1'b0);
    check("ready_after_done", bus.req_ready, 1'b1);
    check("idle_after_done", bus.busy, 1'b0);
  endtask

  task automatic run_bad(logic [8:0] m, logic [8:0] d);
    expq.push_back('{K_ERR, 1'b0, 0});
    issue(m, d);
    check("err_pulse", bus.err, 1'b1);
    check("bad_progen", progen, 1'b0);
    check("bad_ready", bus.req_ready, 1'b1);
    check("bad_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    check("err_single", bus.err, 1'b0);
    check("bad_progen2", progen, 1'b0);
  endtask

  initial begin : stim
    bus.req_valid = 1'b0;
    bus.req_m = '0;
    bus.req_d = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_progen", progen, 1'b0);
    check("rst_progdata", progdata, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.req_ready, 1'b1);
    rst = 1'b0;

    run_ok(9'd35, 9'd8, VD_8, VM_35);
    run_bad(9'd1, 9'd8);
    run_bad(9'd35, 9'd0);
    run_bad(9'd257, 9'd8);
    run_bad(9'd35, 9'd257);
    run_ok(9'd256, 9'd256, VD_256, VM_256);
    run_ok(9'd2, 9'd1, VD_1, VM_2);

    // Reset while LoadM bit 5 is on the pins.
    push_cmd(VD_8, -1, 10);
    push_cmd(VM_35, GAP, 6);
    issue(9'd35, 9'd8);
    repeat (17) @(posedge clk); #1;
    check("pre_abort_progen", progen, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_progen", progen, 1'b0);
    check("abort_progdata", progdata, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_ready", bus.req_ready, 1'b1);
    rst = 1'b0;
    check("abort_queue", expq.size(), 0);
    run_ok(9'd35, 9'd8, VD_8, VM_35);

    // PROGDONE held high: the handshake never completes.
    push_full(VD_8, VM_35);
`ifdef DCM_CLKGEN_PROG_TIMEOUT_EN
    expq.push_back('{K_ERR, 1'b0, 0});
`endif
    issue(9'd35, 9'd8);
    repeat (24) @(posedge clk); #1;
    check("hold_go_progen", progen, 1'b1);
`ifdef DCM_CLKGEN_PROG_TIMEOUT_EN
    begin
      int n;
      n = 0;
      for (int i = 1; i <= TO + 20; i++) begin
        @(posedge clk); #1;
        if (bus.err) begin n = i; break; end
      end
      check("timeout_cycle", n, TO + 1);
      @(posedge clk); #1;
      check("timeout_idle", bus.busy, 1'b0);
      check("timeout_ready", bus.req_ready, 1'b1);
    end
`else
    repeat (300) @(posedge clk); #1;
    check("hold_busy", bus.busy, 1'b1);
    check("hold_no_done", bus.done, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("hold_reset_idle", bus.busy, 1'b0);
`endif

    for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
